// File: rtl/operand_skid_reg.sv
// operand_skid_reg
//
// Two-entry skid register between register-file read and the ALU stage.
// A main register drives out_data; a skid register absorbs one extra operand
// set when the consumer stalls. This keeps in_ready a registered signal that
// does not depend combinationally on out_ready. All NCH channels move together.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous discard of all held operand sets
//   in_valid   upstream presents an operand set
//   in_ready   block can accept a set this cycle (registered)
//   in_data    operand set; channel k at bits [k*WIDTH +: WIDTH]
//   out_valid  out_data holds a valid operand set
//   out_ready  downstream consumes the set this cycle
//   out_data   registered operand set, same packing as in_data
//   count      number of sets held (0, 1 or 2)
//
// Configuration macro:
//   OPERAND_SKID_ZERO_EN  when defined, out_data reads all-zero whenever out_valid is 0;
//                         otherwise out_data always shows the main register.

module operand_skid_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [1:0]           count
);

    localparam int unsigned DW = NCH * WIDTH;

    // State also serves as the full flags: main full in StOne/StTwo, skid full in StTwo.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   main_q, main_d;
    logic [DW-1:0]   skid_q, skid_d;
    logic            in_xfer;
    logic            out_xfer;

    // Handshake outputs depend only on the state register.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        count     = 2'd0;
        case (state_q)
            StEmpty: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                count     = 2'd0;
            end
            StOne: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                count     = 2'd1;
            end
            StTwo: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                count     = 2'd2;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                count     = 2'd0;
            end
        endcase
    end

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Data registers keep their contents; only occupancy is dropped.
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end else if (in_xfer) begin
                        state_d = StTwo;
                        skid_d  = in_data;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only the drain path exists.
                    if (out_xfer) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef OPERAND_SKID_ZERO_EN
    assign out_data = out_valid ? main_q : '0;
`else
    assign out_data = main_q;
`endif

endmodule

// File: tb/tb_operand_skid_reg.sv
module tb_operand_skid_reg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NCH   = 2;
    localparam int unsigned DW    = WIDTH * NCH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    count;

    int nchecks = 0;
    int nerrors = 0;

    // Reference model: FIFO of accepted sets (capacity 2) plus the last set shown on main.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_main = '0;

    operand_skid_reg #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_data();
`ifdef OPERAND_SKID_ZERO_EN
        return (mq.size() > 0) ? mq[0] : '0;
`else
        return m_main;
`endif
    endfunction

    function automatic logic [1:0] exp_count();
        return 2'(mq.size());
    endfunction

    task automatic model_reset();
        mq.delete();
        m_main = '0;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle 1 time unit past the edge.
    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic fl);
        logic acc_in, acc_out;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        acc_in    = iv && (mq.size() < 2);
        acc_out   = ordy && (mq.size() > 0);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (acc_out) void'(mq.pop_front());
            if (acc_in) mq.push_back(d);
        end
        if (mq.size() > 0) m_main = mq[0];
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        nchecks++;
        if (count !== 2'd0) begin
            nerrors++; $display("FAIL reset_count: got %0d want 0", count);
        end
        nchecks++;
        if (out_valid !== 1'b0) begin
            nerrors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        nchecks++;
        if (in_ready !== 1'b1) begin
            nerrors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        nchecks++;
        if (out_data !== '0) begin
            nerrors++; $display("FAIL reset_out_data: got %h want 0", out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a, b;
        a = 64'h22222222_11111111;
        b = 64'h44444444_33333333;
        cycle(1'b1, a, 1'b1, 1'b0);
        nchecks++;
        if (out_valid !== 1'b1 || out_data !== a) begin
            nerrors++; $display("FAIL b2b_first: got v=%b %h want v=1 %h", out_valid, out_data, a);
        end
        cycle(1'b1, b, 1'b1, 1'b0);
        nchecks++;
        if (out_valid !== 1'b1 || out_data !== b || count !== 2'd1) begin
            nerrors++;
            $display("FAIL b2b_second: got v=%b c=%0d %h want v=1 c=1 %h",
                     out_valid, count, out_data, b);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        nchecks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            nerrors++; $display("FAIL b2b_drain: got v=%b c=%0d want v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] a, b, c;
        a = 64'hAAAA0001_AAAA0000;
        b = 64'hBBBB0001_BBBB0000;
        c = 64'hCCCC0001_CCCC0000;
        cycle(1'b1, a, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0);
        nchecks++;
        if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== a) begin
            nerrors++;
            $display("FAIL stall_full: got c=%0d rdy=%b %h want c=2 rdy=0 %h",
                     count, in_ready, out_data, a);
        end
        cycle(1'b1, c, 1'b0, 1'b0);
        nchecks++;
        if (count !== 2'd2 || out_data !== a) begin
            nerrors++; $display("FAIL stall_hold: got c=%0d %h want c=2 %h", count, out_data, a);
        end
        cycle(1'b1, c, 1'b1, 1'b0);
        nchecks++;
        if (count !== 2'd1 || out_data !== b) begin
            nerrors++; $display("FAIL stall_drain_b: got c=%0d %h want c=1 %h", count, out_data, b);
        end
        cycle(1'b1, c, 1'b1, 1'b0);
        nchecks++;
        if (count !== 2'd1 || out_data !== c) begin
            nerrors++; $display("FAIL stall_drain_c: got c=%0d %h want c=1 %h", count, out_data, c);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        nchecks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            nerrors++; $display("FAIL stall_empty: got c=%0d v=%b want c=0 v=0", count, out_valid);
        end
    endtask

    task automatic test_in_out_same();
        logic [DW-1:0] d, e;
        d = 64'hDDDD0001_DDDD0000;
        e = 64'hEEEE0001_EEEE0000;
        cycle(1'b1, d, 1'b0, 1'b0);
        cycle(1'b1, e, 1'b1, 1'b0);
        nchecks++;
        if (count !== 2'd1 || out_data !== e || out_valid !== 1'b1) begin
            nerrors++;
            $display("FAIL in_out_same: got c=%0d v=%b %h want c=1 v=1 %h",
                     count, out_valid, out_data, e);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        logic [DW-1:0] f, g, h, j, want;
        f = 64'hF0F00001_F0F00000;
        g = 64'h0F0F0001_0F0F0000;
        h = 64'h12340001_12340000;
        j = 64'h56780001_56780000;
        cycle(1'b1, f, 1'b0, 1'b0);
        cycle(1'b1, g, 1'b0, 1'b0);
        cycle(1'b1, h, 1'b1, 1'b1);
`ifdef OPERAND_SKID_ZERO_EN
        want = '0;
`else
        want = f;
`endif
        nchecks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerrors++;
            $display("FAIL flush_state: got c=%0d v=%b rdy=%b want c=0 v=0 rdy=1",
                     count, out_valid, in_ready);
        end
        nchecks++;
        if (out_data !== want) begin
            nerrors++; $display("FAIL flush_data: got %h want %h", out_data, want);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        nchecks++;
        if (count !== 2'd0) begin
            nerrors++; $display("FAIL flush_dropped: got c=%0d want 0", count);
        end
        cycle(1'b1, j, 1'b1, 1'b0);
        nchecks++;
        if (count !== 2'd1 || out_data !== j) begin
            nerrors++; $display("FAIL flush_after: got c=%0d %h want c=1 %h", count, out_data, j);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] k;
        k = 64'h0BAD0001_0BAD0000;
        cycle(1'b1, 64'h1, 1'b0, 1'b0);
        cycle(1'b1, 64'h2, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        nchecks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            nerrors++;
            $display("FAIL reset_mid: got c=%0d v=%b rdy=%b %h want c=0 v=0 rdy=1 0",
                     count, out_valid, in_ready, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, k, 1'b0, 1'b0);
        nchecks++;
        if (count !== 2'd1 || out_data !== k) begin
            nerrors++; $display("FAIL reset_mid_after: got c=%0d %h want c=1 %h", count, out_data, k);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic          iv, ordy, fl;
        logic [DW-1:0] d;
        int            bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            iv   = 1'($urandom_range(0, 3) != 0);
            ordy = 1'($urandom_range(0, 2) != 0);
            fl   = 1'($urandom_range(0, 15) == 0);
            d    = {$urandom, $urandom};
            cycle(iv, d, ordy, fl);
            nchecks++;
            if (count !== exp_count()) begin
                nerrors++; bad++;
                if (bad < 10) $display("FAIL rand_count[%0d]: got %0d want %0d", i, count, exp_count());
            end
            nchecks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
                nerrors++; bad++;
                if (bad < 10)
                    $display("FAIL rand_hs[%0d]: got v=%b rdy=%b want v=%b rdy=%b", i, out_valid,
                             in_ready, mq.size() > 0, mq.size() < 2);
            end
            nchecks++;
            if (out_data !== exp_data()) begin
                nerrors++; bad++;
                if (bad < 10) $display("FAIL rand_data[%0d]: got %h want %h", i, out_data, exp_data());
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_in_out_same();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule

// File: doc/operand_skid_reg.md
OPERAND_SKID_REG -- requirements
Module: operand_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32, bit width of one operand channel.
REQ-002 Parameter NCH, default 2, number of operand channels carried in parallel (NCH >= 1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 flush  input  1  synchronous discard of all held operand sets.
REQ-006 in_valid  input  1  upstream (register-file read) presents an operand set.
REQ-007 in_ready  output  1  block accepts a set this cycle; registered, not combinational from out_ready.
REQ-008 in_data  input  NCH*WIDTH  operand set; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 out_valid  output  1  out_data holds a valid operand set for the ALU stage.
REQ-010 out_ready  input  1  downstream consumes the set this cycle.
REQ-011 out_data  output  NCH*WIDTH  registered operand set, same channel packing as in_data.
REQ-012 count  output  2  number of sets held: 0, 1 or 2.

Function
REQ-013 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; each at a rising clk edge.
REQ-014 Storage is a main register (drives out_data) and one skid register, each NCH*WIDTH bits plus a full flag.
REQ-015 State machine states: EMPTY (count 0), ONE (main full, count 1), TWO (main and skid full, count 2).
REQ-016 EMPTY: transfer in -> ONE, in_data loaded into main; else stay.
REQ-017 ONE: in only -> TWO, in_data into skid; out only -> EMPTY; in and out -> ONE, in_data into main; neither -> stay.
REQ-018 TWO: out -> ONE, skid contents moved into main; in_ready is 0 so no transfer in is possible.
REQ-019 in_ready = 1 in EMPTY and ONE, 0 in TWO; out_valid = 1 in ONE and TWO.
REQ-020 Latency: a set accepted in EMPTY appears on out_data with out_valid one cycle later; throughput one set per cycle while out_ready = 1.
REQ-021 Sets leave in acceptance order; no set is duplicated, dropped or reordered except by flush or reset.
REQ-022 Main register holds its value while out_valid = 1 and out_ready = 0 (stall-stable output).
REQ-023 flush = 1 at an edge -> next state EMPTY regardless of in_valid/out_ready; a coincident in_valid is discarded.
REQ-024 Data registers are not cleared by flush; only full flags and state change.
REQ-025 All channels are loaded and moved together; no per-channel enables.

Reset
REQ-026 rst = 1 asynchronously forces state EMPTY, count 0, out_valid 0, in_ready 1, main and skid registers all-zero.
REQ-027 rst asserted mid-transfer discards all held sets; first transfer in after rst deasserts behaves as from EMPTY.
REQ-028 rst has priority over flush and all handshake inputs.

Configuration
REQ-029 Macro OPERAND_SKID_ZERO_EN defined: out_data is forced to all-zero whenever out_valid = 0.
REQ-030 Macro OPERAND_SKID_ZERO_EN undefined: out_data always shows the main register, retaining its last value when out_valid = 0.
REQ-031 Handshake, count and timing are identical with and without the macro.

Verification
REQ-032 rst pulse mid-stream with count = 2 -> immediately count 0, out_valid 0, in_ready 1, out_data 0.
REQ-033 WIDTH 32, NCH 2, out_ready = 1, send 0x11111111/0x22222222 then 0x33333333/0x44444444 back-to-back -> both appear on consecutive cycles one cycle after acceptance, in order.
REQ-034 out_ready = 0, send sets A, B, C -> A, B accepted, in_ready drops to 0 after B, count 2, out_data = A held stable; raise out_ready -> A, B, C emerge in order.
REQ-035 count = 2, flush = 1 with in_valid = 1 -> next cycle count 0, out_valid 0, offered set not accepted.
REQ-036 count = 1, in_valid = 1 and out_ready = 1 same cycle -> count stays 1, out_data updates to new set.
REQ-037 Run REQ-035 with and without OPERAND_SKID_ZERO_EN -> out_data 0 versus last main value after flush.
